// File: rtl/serial_cmd_pkg.sv
// Shared constants and state encoding for the serial command bridge.
// Frame command bytes, response codes and the bridge FSM states.
package serial_cmd_pkg;

    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;

    localparam logic [7:0] RSP_RD_OK  = 8'h81;
    localparam logic [7:0] RSP_WR_OK  = 8'h82;
    localparam logic [7:0] RSP_BADCMD = 8'hE1;
    localparam logic [7:0] RSP_BUSTO  = 8'hE2;

    localparam int RESP_BYTES = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RX_AH = 3'd1,
        S_RX_AL = 3'd2,
        S_RX_DH = 3'd3,
        S_RX_DL = 3'd4,
        S_BUS   = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    function automatic logic is_rx_state(input state_t s);
        logic r;
        case (s)
            S_RX_AH, S_RX_AL, S_RX_DH, S_RX_DL: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_resp_tx.sv
// Response sender: shifts out up to three loaded bytes to the UART transmitter,
// pacing strobes on tx_busy and never strobing in two consecutive cycles.
module serial_resp_tx
    import serial_cmd_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [8*RESP_BYTES-1:0]   load_bytes,
    input  logic [1:0]                load_cnt,
    input  logic                      tx_busy,
    output logic [7:0]                tx_data,
    output logic                      tx_dstrb,
    output logic                      done
);

    logic [8*RESP_BYTES-1:0] shift_r;
    logic [1:0]              left_r;
    logic [7:0]              tx_data_r;
    logic                    tx_dstrb_r;
    logic                    done_r;

    // Byte shifter; a strobe in the previous cycle blocks this one because the
    // UART only raises tx_busy a cycle after it sees a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r    <= {(8*RESP_BYTES){1'b0}};
            left_r     <= 2'd0;
            tx_data_r  <= 8'h00;
            tx_dstrb_r <= 1'b0;
            done_r     <= 1'b0;
        end else if (load) begin
            shift_r    <= load_bytes;
            left_r     <= load_cnt;
            tx_dstrb_r <= 1'b0;
            done_r     <= 1'b0;
        end else if ((left_r != 2'd0) && !tx_busy && !tx_dstrb_r) begin
            tx_data_r  <= shift_r[8*RESP_BYTES-1 -: 8];
            shift_r    <= {shift_r[8*RESP_BYTES-9:0], 8'h00};
            left_r     <= left_r - 2'd1;
            tx_dstrb_r <= 1'b1;
            done_r     <= (left_r == 2'd1);
        end else begin
            tx_dstrb_r <= 1'b0;
            done_r     <= 1'b0;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_dstrb = tx_dstrb_r;
    assign done     = done_r;

endmodule

// File: rtl/serial_cmd_bridge.sv
// Serial command bridge: parses READ/WRITE frames from the UART, runs one
// register-bus transaction per frame and returns the response frame.
module serial_cmd_bridge
    import serial_cmd_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT  = 1000000,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_dstrb,
    output logic        rx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_dstrb,
    input  logic        tx_busy,
    output logic [15:0] bus_adr,
    output logic [15:0] bus_dat_o,
    input  logic [15:0] bus_dat_i,
    output logic        bus_we,
    output logic        bus_strb,
    input  logic        bus_ack
);

    localparam int RX_CW  = $clog2(RX_TIMEOUT + 1);
    localparam int BUS_CW = $clog2(BUS_TIMEOUT + 1);

    state_t              state_r;
    state_t              state_nx_s;
    logic [RX_CW-1:0]    rx_cnt_r;
    logic [BUS_CW-1:0]   bus_cnt_r;
    logic                rx_to_s;
    logic                bus_to_s;
    logic                ack_ok_s;
    logic                load_s;
    logic [8*RESP_BYTES-1:0] load_bytes_s;
    logic [1:0]          load_cnt_s;
    logic                tx_done_s;
    logic                rx_busy_r;
    logic                bus_strb_r;
    logic                bus_we_r;
    logic [15:0]         bus_adr_r;
    logic [15:0]         bus_dat_o_r;

    assign rx_to_s  = (rx_cnt_r == RX_CW'(RX_TIMEOUT));
    assign bus_to_s = (bus_cnt_r == BUS_CW'(BUS_TIMEOUT));
    // The strobe cycle itself has bus_cnt_r == 0, so an ack there is ignored.
    assign ack_ok_s = bus_ack && (bus_cnt_r != {BUS_CW{1'b0}});

    // Next-state decode and response loading.
    always_comb begin
        state_nx_s   = state_r;
        load_s       = 1'b0;
        load_bytes_s = {(8*RESP_BYTES){1'b0}};
        load_cnt_s   = 2'd0;
        case (state_r)
            S_IDLE: begin
                if (rx_dstrb) begin
                    if ((rx_data == CMD_READ) || (rx_data == CMD_WRITE)) begin
                        state_nx_s = S_RX_AH;
                    end else begin
                        state_nx_s   = S_RESP;
                        load_s       = 1'b1;
                        load_bytes_s = {RSP_BADCMD, 16'h0000};
                        load_cnt_s   = 2'd1;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RX_AH, S_RX_AL, S_RX_DH, S_RX_DL: begin
                if (rx_dstrb) begin
                    if (state_r == S_RX_AH) begin
                        state_nx_s = S_RX_AL;
                    end else if (state_r == S_RX_AL) begin
                        state_nx_s = bus_we_r ? S_RX_DH : S_BUS;
                    end else if (state_r == S_RX_DH) begin
                        state_nx_s = S_RX_DL;
                    end else begin
                        state_nx_s = S_BUS;
                    end
                end else if (rx_to_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_BUS: begin
                if (ack_ok_s) begin
                    state_nx_s = S_RESP;
                    load_s     = 1'b1;
                    if (bus_we_r) begin
                        load_bytes_s = {RSP_WR_OK, 16'h0000};
                        load_cnt_s   = 2'd1;
                    end else begin
                        load_bytes_s = {RSP_RD_OK, bus_dat_i};
                        load_cnt_s   = 2'd3;
                    end
                end else if (bus_to_s) begin
                    state_nx_s   = S_RESP;
                    load_s       = 1'b1;
                    load_bytes_s = {RSP_BUSTO, 16'h0000};
                    load_cnt_s   = 2'd1;
                end else begin
                    state_nx_s = S_BUS;
                end
            end
            S_RESP: begin
                if (tx_done_s) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_RESP;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, flow control, timeout counters and frame capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            rx_busy_r   <= 1'b0;
            bus_strb_r  <= 1'b0;
            rx_cnt_r    <= {RX_CW{1'b0}};
            bus_cnt_r   <= {BUS_CW{1'b0}};
            bus_we_r    <= 1'b0;
            bus_adr_r   <= 16'h0000;
            bus_dat_o_r <= 16'h0000;
        end else begin
            state_r    <= state_nx_s;
            rx_busy_r  <= (state_nx_s == S_BUS) || (state_nx_s == S_RESP);
            bus_strb_r <= (state_nx_s == S_BUS) && (state_r != S_BUS);

            if (is_rx_state(state_r) && !rx_dstrb) begin
                if (!rx_to_s) begin
                    rx_cnt_r <= rx_cnt_r + RX_CW'(1);
                end
            end else begin
                rx_cnt_r <= {RX_CW{1'b0}};
            end

            if (state_r == S_BUS) begin
                if (!bus_to_s) begin
                    bus_cnt_r <= bus_cnt_r + BUS_CW'(1);
                end
            end else begin
                bus_cnt_r <= {BUS_CW{1'b0}};
            end

            if (rx_dstrb) begin
                case (state_r)
                    S_IDLE: begin
                        if ((rx_data == CMD_READ) || (rx_data == CMD_WRITE)) begin
                            bus_we_r    <= (rx_data == CMD_WRITE);
                            bus_dat_o_r <= 16'h0000;
                        end
                    end
                    S_RX_AH: bus_adr_r[15:8]   <= rx_data;
                    S_RX_AL: bus_adr_r[7:0]    <= rx_data;
                    S_RX_DH: bus_dat_o_r[15:8] <= rx_data;
                    S_RX_DL: bus_dat_o_r[7:0]  <= rx_data;
                    default: begin
                    end
                endcase
            end
        end
    end

    serial_resp_tx u_resp_tx (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_bytes (load_bytes_s),
        .load_cnt   (load_cnt_s),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_dstrb   (tx_dstrb),
        .done       (tx_done_s)
    );

    assign rx_busy   = rx_busy_r;
    assign bus_strb  = bus_strb_r;
    assign bus_we    = bus_we_r;
    assign bus_adr   = bus_adr_r;
    assign bus_dat_o = bus_dat_o_r;

endmodule

// File: tb/tb_serial_cmd_bridge.sv
// Directed scoreboard bench for serial_cmd_bridge with a UART busy model and
// a bus responder whose ack delay is chosen per frame.
module tb_serial_cmd_bridge;

    localparam int RX_TO  = 50;
    localparam int BUS_TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_dstrb = 1'b0;
    logic        rx_busy;
    logic [7:0]  tx_data;
    logic        tx_dstrb;
    logic        tx_busy = 1'b0;
    logic [15:0] bus_adr;
    logic [15:0] bus_dat_o;
    logic [15:0] bus_dat_i = 16'h0000;
    logic        bus_we;
    logic        bus_strb;
    logic        bus_ack = 1'b0;

    typedef struct packed {
        logic [15:0] adr;
        logic [15:0] dat;
        logic        we;
        logic        chk_dat;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [7:0]  tx_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_tx = -100;
    int          first_tx = -1;
    int          last_bus = -100;
    int          busy_hold = 0;
    int          ack_delay = -1;
    int          ack_at = -1;
    logic [15:0] rd_val = 16'h0000;

    serial_cmd_bridge #(.RX_TIMEOUT(RX_TO), .BUS_TIMEOUT(BUS_TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_dstrb  (rx_dstrb),
        .rx_busy   (rx_busy),
        .tx_data   (tx_data),
        .tx_dstrb  (tx_dstrb),
        .tx_busy   (tx_busy),
        .bus_adr   (bus_adr),
        .bus_dat_o (bus_dat_o),
        .bus_dat_i (bus_dat_i),
        .bus_we    (bus_we),
        .bus_strb  (bus_strb),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_true(input string tag, input bit cond);
        tests++;
        assert (cond === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed 0 expected 1", tag);
        end
    endtask

    // One clock: sample outputs, score strobes, then drive the responders.
    task automatic tick();
        bus_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_dstrb === 1'b1) begin
            check_true("tx_expected", tx_q.size() != 0);
            if (tx_q.size() != 0) check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
            check_true("tx_spacing", (cyc - last_tx) >= (2 + busy_hold));
            last_tx = cyc;
            if (first_tx < 0) first_tx = cyc;
        end
        if (bus_strb === 1'b1) begin
            check_true("bus_expected", bus_q.size() != 0);
            if (bus_q.size() != 0) begin
                e = bus_q.pop_front();
                check("bus_adr", 32'(bus_adr), 32'(e.adr));
                check("bus_we", 32'(bus_we), 32'(e.we));
                if (e.chk_dat) check("bus_dat_o", 32'(bus_dat_o), 32'(e.dat));
            end
            last_bus = cyc;
            if (ack_delay >= 0) ack_at = cyc + ack_delay;
        end
        bus_ack   = (cyc == ack_at);
        bus_dat_i = bus_ack ? rd_val : 16'h0000;
        tx_busy   = (busy_hold > 0) && (cyc > last_tx) && (cyc <= last_tx + busy_hold);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_dstrb = 1'b1;
        tick();
        rx_dstrb = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic exp_bus(input logic [15:0] adr, input logic [15:0] dat, input logic we, input logic chk);
        bus_exp_t e;
        e.adr = adr;
        e.dat = dat;
        e.we = we;
        e.chk_dat = chk;
        bus_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, 32'({rx_busy, tx_dstrb, bus_strb, bus_we}), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_bus_adr"}, 32'(bus_adr), 32'd0);
        check({tag, "_bus_dat_o"}, 32'(bus_dat_o), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        bit done_w = 1'b0;
        for (int i = 0; i < 400 && !done_w; i++) begin
            tick();
            if (rx_busy === 1'b0) done_w = 1'b1;
        end
        check_true({tag, "_idle_bound"}, done_w);
        check_true({tag, "_busy_drop"}, cyc == last_tx + 1);
        check_true({tag, "_tx_drained"}, tx_q.size() == 0);
        check_true({tag, "_bus_drained"}, bus_q.size() == 0);
    endtask

    task automatic run_frame(input string tag, input logic [39:0] fr, input int n);
        first_tx = -1;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) check({tag, "_busy_pre"}, 32'(rx_busy), 32'd0);
            send_byte(fr[8*(n-1-i) +: 8]);
        end
        check({tag, "_busy_post"}, 32'(rx_busy), 32'd1);
        wait_idle(tag);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Write, ack three cycles after the strobe.
        ack_delay = 3;
        exp_bus(16'h1234, 16'hABCD, 1'b1, 1'b1);
        tx_q.push_back(8'h82);
        run_frame("wr", 40'h02_1234_ABCD, 5);
        check_true("wr_latency", first_tx - last_bus == 5);

        // Read against a slow UART.
        busy_hold = 20;
        ack_delay = 2;
        rd_val = 16'hBEEF;
        exp_bus(16'h0010, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'h81); tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
        run_frame("rd", 40'h00_0001_0010, 3);
        busy_hold = 0;

        // Bad command, then a normal read.
        tx_q.push_back(8'hE1);
        run_frame("bad", 40'h55, 1);
        ack_delay = 1;
        rd_val = 16'h1357;
        exp_bus(16'h0000, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'h81); tx_q.push_back(8'h13); tx_q.push_back(8'h57);
        run_frame("bad_rd", 40'h01_0000, 3);

        // Ack on the terminal count still completes the write.
        ack_delay = BUS_TO;
        exp_bus(16'h0001, 16'h0002, 1'b1, 1'b1);
        tx_q.push_back(8'h82);
        run_frame("ack_tc", 40'h02_0001_0002, 5);
        check_true("ack_tc_latency", first_tx - last_bus == BUS_TO + 2);

        // Ack one cycle too late: bus timeout.
        ack_delay = BUS_TO + 1;
        exp_bus(16'h0003, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'hE2);
        run_frame("bus_to", 40'h01_0003, 3);
        check_true("bus_to_latency", first_tx - last_bus == BUS_TO + 2);

        // Ack only on the strobe cycle is not counted.
        ack_delay = 0;
        exp_bus(16'h0005, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'hE2);
        run_frame("ack_strb", 40'h01_0005, 3);
        check_true("ack_strb_latency", first_tx - last_bus == BUS_TO + 2);

        ack_delay = 1;
        rd_val = 16'hCAFE;
        exp_bus(16'h0004, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'h81); tx_q.push_back(8'hCA); tx_q.push_back(8'hFE);
        run_frame("rd_after_to", 40'h01_0004, 3);
        check_true("rd_after_to_latency", first_tx - last_bus == 3);

        // Inter-byte timeout abandons the partial frame silently.
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (60) tick();
        check("rxto_idle_busy", 32'(rx_busy), 32'd0);
        rd_val = 16'h1111;
        exp_bus(16'h0020, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'h81); tx_q.push_back(8'h11); tx_q.push_back(8'h11);
        run_frame("rxto_rd", 40'h01_0020, 3);

        // Byte on the terminal-count cycle is accepted.
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (RX_TO) tick();
        exp_bus(16'h1234, 16'hABCD, 1'b1, 1'b1);
        tx_q.push_back(8'h82);
        run_frame("rxto_tc", 40'h34_ABCD, 3);

        // One cycle later the bridge is idle again and 0x01 starts a read.
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (RX_TO + 1) tick();
        rd_val = 16'h2222;
        exp_bus(16'h0030, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'h81); tx_q.push_back(8'h22); tx_q.push_back(8'h22);
        run_frame("rxto_late", 40'h01_0030, 3);

        // Reset in the middle of a read response.
        busy_hold = 20;
        ack_delay = 2;
        rd_val = 16'h4242;
        exp_bus(16'h00A0, 16'h0000, 1'b0, 1'b0);
        tx_q.push_back(8'h81);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hA0);
        check("mid_busy_post", 32'(rx_busy), 32'd1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                tick();
                if (tx_q.size() == 0) seen = 1'b1;
            end
            check_true("mid_first_byte", seen);
        end
        repeat (3) tick();
        reset = 1'b1;
        ack_delay = -1;
        tick();
        check_reset_vals("mid_rst");
        reset = 1'b0;
        ack_at = cyc + 2;
        repeat (40) tick();
        check("mid_quiet_busy", 32'(rx_busy), 32'd0);

        busy_hold = 0;
        ack_delay = 1;
        exp_bus(16'h5678, 16'h9ABC, 1'b1, 1'b1);
        tx_q.push_back(8'h82);
        run_frame("post_rst_wr", 40'h02_5678_9ABC, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_cmd_bridge.md
Name: serial_cmd_bridge

Overview:
Host-side protocol endpoint for the serial UART byte interface. It consumes received bytes from the UART, parses fixed-length register read and write frames, and runs one transaction on a 16-bit register bus. It then returns a response frame byte-by-byte to the UART transmitter. It sits between serial_uart and the monitor register bus and provides the UART's flow-control input.

Parameters:
RX_TIMEOUT, 1000000, inter-byte timeout in clk cycles (100 ms at 10 MHz)
BUS_TIMEOUT, 255, cycles to wait for bus_ack after bus_strb

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte; valid when rx_dstrb=1
rx_dstrb  input  1  one-cycle strobe: rx_data valid
rx_busy  output  1  bridge cannot accept bytes; drives the UART busy input (deasserts CTS)
tx_data  output  8  byte to transmit; valid when tx_dstrb=1
tx_dstrb  output  1  one-cycle strobe: send tx_data
tx_busy  input  1  UART transmitter busy
bus_adr  output  16  register address
bus_dat_o  output  16  write data
bus_dat_i  input  16  read data; valid when bus_ack=1
bus_we  output  1  1 = write, 0 = read
bus_strb  output  1  one-cycle transaction request
bus_ack  input  1  transaction complete

Behaviour:
- Reset (clk, reset: synchronous, active-high): the next edge forces state IDLE.
  - rx_busy=0, tx_dstrb=0, tx_data=0x00, bus_strb=0, bus_we=0, bus_adr=0x0000, bus_dat_o=0x0000.
  - Reset mid-frame, mid-bus or mid-response abandons all work; no further strobes are issued.
  - A bus_ack arriving after reset is ignored.
- Frames, byte order MSB first:
  - READ: 0x01, AH, AL.
  - WRITE: 0x02, AH, AL, DH, DL.
- States and transitions:
  - IDLE: on rx_dstrb, 0x01 → RX_AH with we=0; 0x02 → RX_AH with we=1; any other byte → RESP with the code 0xE1.
  - RX_AH → RX_AL.
  - RX_AL → BUS for a read, RX_DH for a write.
  - RX_DH → RX_DL → BUS.
- rx_busy:
  - Asserts the cycle after the final frame byte is accepted (or after a bad command byte).
  - Stays high through BUS and RESP.
  - Deasserts the cycle after the last response strobe.
  - Bytes strobed while rx_busy=1 are dropped.
- Inter-byte timeout:
  - In any RX_* state, a counter is cleared on each accepted byte.
  - When it reaches RX_TIMEOUT with no byte, the bridge returns to IDLE silently.
  - If rx_dstrb coincides with the terminal count, the byte wins.
- BUS state:
  - bus_strb pulses for exactly one cycle on BUS entry.
  - bus_adr, bus_dat_o and bus_we are valid on the strobe cycle and held until leaving BUS.
  - bus_ack counts only from the cycle after the strobe.
  - On ack, capture bus_dat_i (reads) and go to RESP.
  - If BUS_TIMEOUT cycles after the strobe pass with no ack, go to RESP with 0xE2.
  - Ack on the terminal-count cycle wins.
- RESP byte lists:
  - Write OK: 0x82.
  - Read OK: 0x81, DH, DL.
  - Errors: a single byte, 0xE1 (bad command) or 0xE2 (bus timeout).
- TX handshake:
  - tx_dstrb is a one-cycle pulse with tx_data valid in the same cycle.
  - Issued only when tx_busy=0.
  - Never issued in the cycle immediately after a previous tx_dstrb, because the UART raises busy one cycle late.
  - Minimum strobe spacing is 2 cycles plus the tx_busy high time.
  - After the last byte the bridge returns to IDLE.
- Counter widths come from clog2 of the timeout parameters; counters saturate and never wrap.

Decomposition:
- Package serial_cmd_pkg:
  - command codes CMD_READ=0x01, CMD_WRITE=0x02;
  - response codes RSP_RD_OK=0x81, RSP_WR_OK=0x82, RSP_BADCMD=0xE1, RSP_BUSTO=0xE2;
  - state encoding.
- One sub-module, serial_resp_tx:
  - loads up to 3 bytes plus a count;
  - performs the tx_dstrb/tx_busy handshake with the one-cycle guard;
  - pulses done after the last strobe.

Test Plan:
- WRITE: rx 02 12 34 AB CD → single bus_strb, adr=0x1234, dat_o=0xABCD, we=1. Ack 3 cycles later → tx exactly 0x82; rx_busy high from the cycle after CD until the cycle after that strobe.
- READ: rx 01 00 10, bus_dat_i=0xBEEF with ack → tx 81 BE EF. Bench holds tx_busy high 20 cycles per byte; check no strobe while busy and no back-to-back strobes.
- Bad command: rx 0x55 → tx E1, no bus_strb; then rx 01 00 00 → normal read completes.
- Bus timeout: BUS_TIMEOUT=8, no ack → tx E2 exactly 8 cycles after the strobe window. A late ack is ignored; the next frame is unaffected.
- Inter-byte timeout: RX_TIMEOUT=50, rx 02 12 then silence → back to IDLE, no tx, no bus_strb. A byte arriving on the terminal-count cycle is accepted instead.
- Reset during RESP, after byte 0x81 → no further tx_dstrb, all outputs at reset values; the following WRITE frame completes normally.
